// File: rtl/pll_lock_seq.sv
// MMCM reset/lock sequencer on the free-running reference clock: pulses MMCM RST and releases sys_reset_n after stable lock.
// Optional lock-loss counter output enabled by defining PLL_LOSS_CNT_EN.
module pll_lock_seq #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int STABLE_CYC       = 1024,
    parameter int RETRY_MAX        = 15
) (
    input  logic       clk_ref,
    input  logic       reset_n,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       sys_reset_n,
    output logic [1:0] seq_state,
`ifdef PLL_LOSS_CNT_EN
    output logic [7:0] lock_loss_cnt,
`endif
    output logic       lock_fail
);

    localparam int MAX_AB  = (RST_PULSE_CYC > LOCK_TIMEOUT_CYC) ? RST_PULSE_CYC : LOCK_TIMEOUT_CYC;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYC) ? MAX_AB : STABLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
    localparam logic [7:0]       RETRY_LIM   = 8'(RETRY_MAX);

    typedef enum logic [1:0] {
        PLL_RST   = 2'b00,
        WAIT_LOCK = 2'b01,
        SETTLE    = 2'b10,
        RUN       = 2'b11
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       retry;
    logic             sync1, lock_s;
    logic             timeout;

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = SETTLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = PLL_RST;
                    timeout   = 1'b1;
                end
            end
            SETTLE: begin
                // A drop on the completing cycle takes priority over release
                if (!lock_s)                 state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (!lock_s) state_nxt = PLL_RST;
            end
            default: state_nxt = PLL_RST;
        endcase
    end

    always_ff @(posedge clk_ref) begin
        if (!reset_n) begin
            state       <= PLL_RST;
            cnt         <= '0;
            retry       <= '0;
            sync1       <= 1'b0;
            lock_s      <= 1'b0;
            pll_reset   <= 1'b1;
            sys_reset_n <= 1'b0;
            lock_fail   <= 1'b0;
        end else begin
            sync1       <= pll_lock;
            lock_s      <= sync1;
            state       <= state_nxt;
            cnt         <= (state_nxt != state) ? '0 : cnt + 1'b1;
            pll_reset   <= (state_nxt == PLL_RST);
            sys_reset_n <= (state_nxt == RUN);
            if (timeout) begin
                if (retry < RETRY_LIM)          retry     <= retry + 8'd1;
                if (retry >= RETRY_LIM - 8'd1)  lock_fail <= 1'b1;
            end
            if (state == SETTLE && state_nxt == RUN) retry <= '0;
        end
    end

    assign seq_state = state;

`ifdef PLL_LOSS_CNT_EN
    always_ff @(posedge clk_ref) begin
        if (!reset_n)
            lock_loss_cnt <= '0;
        else if (state == RUN && state_nxt == PLL_RST && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Table-driven bench for pll_lock_seq with a small expectation queue; loss-counter checks only with PLL_LOSS_CNT_EN.
module tb_pll_lock_seq;

    localparam int RST_PULSE_CYC    = 4;
    localparam int LOCK_TIMEOUT_CYC = 20;
    localparam int STABLE_CYC       = 8;
    localparam int RETRY_MAX        = 3;
`ifdef PLL_LOSS_CNT_EN
    localparam int N_LOSS = 300;
`else
    localparam int N_LOSS = 3;
`endif

    logic       clk_ref = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_lock = 1'b0;
    logic       pll_reset, sys_reset_n, lock_fail;
    logic [1:0] seq_state;
`ifdef PLL_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    pll_lock_seq #(
        .RST_PULSE_CYC(RST_PULSE_CYC),
        .LOCK_TIMEOUT_CYC(LOCK_TIMEOUT_CYC),
        .STABLE_CYC(STABLE_CYC),
        .RETRY_MAX(RETRY_MAX)
    ) dut (
        .clk_ref(clk_ref),
        .reset_n(reset_n),
        .pll_lock(pll_lock),
        .pll_reset(pll_reset),
        .sys_reset_n(sys_reset_n),
        .seq_state(seq_state),
`ifdef PLL_LOSS_CNT_EN
        .lock_loss_cnt(lock_loss_cnt),
`endif
        .lock_fail(lock_fail)
    );

    always #5 clk_ref = ~clk_ref;

    typedef struct {
        logic       rst_n;
        logic       lock;
        int         ncyc;
        logic [1:0] st;
        logic       prst;
        logic       srn;
        logic       fail;
        int         loss;
        string      tag;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic l, input int n, input logic [1:0] s,
                     input logic pr, input logic sr, input logic f, input int loss, input string tag);
        vec_t e;
        e.rst_n = r; e.lock = l; e.ncyc = n; e.st = s;
        e.prst = pr; e.srn = sr; e.fail = f; e.loss = loss; e.tag = tag;
        vecs.push_back(e);
    endtask

    task automatic check_out();
        vec_t x;
        x = exp_q.pop_front();
        chk({x.tag, ".seq_state"},   32'(seq_state),   32'(x.st));
        chk({x.tag, ".pll_reset"},   32'(pll_reset),   32'(x.prst));
        chk({x.tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(x.srn));
        chk({x.tag, ".lock_fail"},   32'(lock_fail),   32'(x.fail));
`ifdef PLL_LOSS_CNT_EN
        if (x.loss >= 0) chk({x.tag, ".lock_loss_cnt"}, 32'(lock_loss_cnt), 32'(x.loss));
`endif
    endtask

    // Called at a negedge: drive, wait ncyc rising edges, sample at the following negedge
    task automatic apply(input vec_t e);
        reset_n  = e.rst_n;
        pll_lock = e.lock;
        exp_q.push_back(e);
        repeat (e.ncyc) @(posedge clk_ref);
        @(negedge clk_ref);
        check_out();
    endtask

    task automatic wait_state(input logic [1:0] s, input int budget, input string tag);
        int k = 0;
        while (seq_state !== s && k < budget) begin
            @(negedge clk_ref);
            k++;
        end
        n_checks++;
        if (seq_state !== s) begin
            n_fail++;
            $display("FAIL %s: seq_state %0d after %0d cycles, expected %0d", tag, seq_state, budget, s);
        end
    endtask

    initial begin
        // rst lock ncyc state prst srn fail loss
        v(0, 0, 2, 2'd0, 1, 0, 0, 0, "reset");
        v(1, 0, 3, 2'd0, 1, 0, 0, 0, "pulse_hi");
        v(1, 0, 1, 2'd1, 0, 0, 0, 0, "pulse_end");
        v(1, 0, 9, 2'd1, 0, 0, 0, 0, "wait_lock");
        v(1, 1, 2, 2'd1, 0, 0, 0, 0, "sync_lat");
        v(1, 1, 1, 2'd2, 0, 0, 0, 0, "settle_in");
        v(1, 1, 7, 2'd2, 0, 0, 0, 0, "settle_hold");
        v(1, 1, 1, 2'd3, 0, 1, 0, 0, "run_in");
        // lock loss in RUN, then relock with a one-cycle glitch at settle count 5
        v(1, 0, 2, 2'd3, 0, 1, 0, 0, "loss_lat");
        v(1, 0, 1, 2'd0, 1, 0, 0, 1, "loss_rst");
        v(1, 0, 3, 2'd0, 1, 0, 0, 1, "loss_pulse");
        v(1, 0, 1, 2'd1, 0, 0, 0, 1, "loss_pulse_end");
        v(1, 1, 2, 2'd1, 0, 0, 0, 1, "relock_sync");
        v(1, 1, 1, 2'd2, 0, 0, 0, 1, "relock_settle");
        v(1, 1, 5, 2'd2, 0, 0, 0, 1, "glitch_pre");
        v(1, 0, 1, 2'd2, 0, 0, 0, 1, "glitch_lo");
        v(1, 1, 1, 2'd2, 0, 0, 0, 1, "glitch_back");
        v(1, 1, 1, 2'd1, 0, 0, 0, 1, "drop_wins");
        v(1, 1, 1, 2'd2, 0, 0, 0, 1, "resettle");
        v(1, 1, 7, 2'd2, 0, 0, 0, 1, "resettle_hold");
        v(1, 1, 1, 2'd3, 0, 1, 0, 1, "rerun");
        // lock held low: three timeouts, lock_fail on the third
        v(1, 0, 2, 2'd3, 0, 1, 0, 1, "loss2_lat");
        v(1, 0, 1, 2'd0, 1, 0, 0, 2, "loss2_rst");
        for (int t = 1; t <= 3; t++) begin
            v(1, 0, 3,  2'd0, 1, 0, 0, 2, "to_pulse");
            v(1, 0, 1,  2'd1, 0, 0, 0, 2, "to_wait");
            v(1, 0, 19, 2'd1, 0, 0, 0, 2, "to_pre");
            v(1, 0, 1,  2'd0, 1, 0, logic'(t == 3), 2, "to_edge");
        end
        v(1, 0, 3, 2'd0, 1, 0, 1, 2, "fail_pulse");
        v(1, 0, 1, 2'd1, 0, 0, 1, 2, "fail_retry");
        // reach SETTLE with lock_fail set, then reset
        v(1, 1, 2, 2'd1, 0, 0, 1, 2, "f_sync");
        v(1, 1, 1, 2'd2, 0, 0, 1, 2, "f_settle");
        v(1, 1, 3, 2'd2, 0, 0, 1, 2, "f_mid");
        v(0, 1, 1, 2'd0, 1, 0, 0, 0, "mid_reset");
        // released with lock already high: lock ignored during the pulse
        v(1, 1, 3, 2'd0, 1, 0, 0, 0, "rel_pulse");
        v(1, 1, 1, 2'd1, 0, 0, 0, 0, "rel_wait");
        v(1, 1, 1, 2'd2, 0, 0, 0, 0, "rel_settle");
        v(1, 1, 7, 2'd2, 0, 0, 0, 0, "rel_hold");
        v(1, 1, 1, 2'd3, 0, 1, 0, 0, "rel_run");

        @(negedge clk_ref);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // repeated lock losses from RUN; counter saturates at 255
        for (int i = 0; i < N_LOSS; i++) begin
            pll_lock = 1'b0;
            wait_state(2'd0, 8, "loss_enter");
            pll_lock = 1'b1;
            wait_state(2'd3, 40, "loss_relock");
`ifdef PLL_LOSS_CNT_EN
            chk("loss_sat", 32'(lock_loss_cnt), (i + 1 > 255) ? 32'd255 : 32'(i + 1));
`endif
        end
        chk("final_sys_reset_n", 32'(sys_reset_n), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
